fwd_hazard_ctrl: RTL and testbench
==================================

FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single rising-edge clock.
REQ-002 SHALL have port clrn, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have port rs, input, 5 bits: ID-stage source register A.
REQ-004 SHALL have port rt, input, 5 bits: ID-stage source register B.
REQ-005 SHALL have ports use_rs and use_rt, input, 1 bit each: ID instruction reads rs / rt.
REQ-006 SHALL have port rn, input, 5 bits: ID-stage destination register.
REQ-007 SHALL have ports wreg and m2reg, input, 1 bit each: ID instruction writes a register / is a load.
REQ-008 SHALL have port fwda, output, 2 bits: select for operand A forwarding mux.
REQ-009 SHALL have port fwdb, output, 2 bits: select for operand B forwarding mux.
REQ-010 SHALL have port wpcir, output, 1 bit: PC and IF/ID write enable, low = stall.
REQ-011 SHALL have ports ewreg_o and mwreg_o, output, 1 bit each: tracked EX / MEM write-valid flags, for debug.
REQ-012 SHALL have port stall_cnt, output, 16 bits: count of stall cycles.

Function
REQ-013 SHALL encode fwd selects as 00 register file (qa/qb), 01 EX ALU result, 10 MEM ALU result, 11 MEM load data.
REQ-014 SHALL hold EX-stage tracking registers ern (5b), ewreg, em2reg, and MEM-stage registers mrn (5b), mwreg, mm2reg.
REQ-015 SHALL, each rising clk edge: MEM <- EX, then EX <- {rn, wreg, m2reg} when wpcir=1, or EX <- bubble (ewreg=0, em2reg=0, ern=0) when wpcir=0.
REQ-016 SHALL drive fwda combinationally: 01 if use_rs & ewreg & ~em2reg & ern==rs & rs!=0; else 11 if use_rs & mwreg & mm2reg & mrn==rs & rs!=0; else 10 if use_rs & mwreg & ~mm2reg & mrn==rs & rs!=0; else 00.
REQ-017 SHALL drive fwdb by the same rule as REQ-016 with rt/use_rt in place of rs/use_rs.
REQ-018 SHALL give the EX-stage match priority over the MEM-stage match when both stages target the same register.
REQ-019 SHALL deassert wpcir (load-use stall) when ewreg & em2reg & ern!=0 & ((use_rs & ern==rs) | (use_rt & ern==rt)); otherwise wpcir=1.
REQ-020 SHALL force fwda and fwdb to 00 in any cycle where wpcir=0.
REQ-021 SHALL never forward or stall on register 0, even if a tracked stage writes register 0.
REQ-022 SHALL increment stall_cnt by 1 on each clk edge where wpcir=0, saturating at 16'hFFFF (no wrap).
REQ-023 SHALL limit any single load-use stall to exactly one cycle: after the bubble the load sits in MEM and REQ-016 selects 11.

Reset
REQ-024 SHALL, while clrn=0, clear ern, ewreg, em2reg, mrn, mwreg, mm2reg and stall_cnt to 0, independent of clk.
REQ-025 SHALL produce fwda=00, fwdb=00, wpcir=1, ewreg_o=0, mwreg_o=0 while in reset.
REQ-026 SHALL, on reset asserted mid-stall, discard the pending stall; the first post-reset cycle has no forwarding.

Structure
REQ-027 SHALL place the fwd select encodings (FWD_RF=00, FWD_EXALU=01, FWD_MEMALU=10, FWD_MEMDO=11) and the 5-bit register-index width in the shared pipeline package.
REQ-028 SHALL contain one sub-module, fwd_sel, instantiated twice (A and B), computing a 2-bit select from {src, use, tracked EX/MEM state}.
REQ-029 SHALL keep all sequential state in this module, not in fwd_sel.

Verification
REQ-030 Bench SHALL show ALU producer then dependent consumer: cycle1 rn=5, wreg=1, m2reg=0; cycle2 rs=5, use_rs=1 -> fwda=01, wpcir=1.
REQ-031 Bench SHALL show two-apart dependency: producer rn=7 (ALU), one unrelated instr, then rt=7, use_rt=1 -> fwdb=10.
REQ-032 Bench SHALL show load-use: load rn=3, m2reg=1; next rs=3 -> wpcir=0 for one cycle, fwda=00, stall_cnt 0->1; following cycle fwda=11, wpcir=1.
REQ-033 Bench SHALL show EX priority: rn=9 ALU, then rn=9 ALU, then rs=9 -> fwda=01, not 10.
REQ-034 Bench SHALL show register 0: producer rn=0, wreg=1, then rs=0, use_rs=1 -> fwda=00, wpcir=1, even with m2reg=1.
REQ-035 Bench SHALL show reset mid-stall: clrn low during wpcir=0 -> wpcir=1, stall_cnt=0, tracking cleared; preloaded stall_cnt=16'hFFFF plus one stall holds at FFFF.

Source files
------------

// File: rtl/fwd_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_ctrl_pkg
// Brief    : Shared pipeline types: register index width, forward selects,
//            and the tracked per-stage destination record.
// Revision : 1.0
// ============================================================================
package fwd_hazard_ctrl_pkg;

    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        FWD_RF     = 2'b00,
        FWD_EXALU  = 2'b01,
        FWD_MEMALU = 2'b10,
        FWD_MEMDO  = 2'b11
    } fwd_t;

    typedef struct packed {
        reg_idx_t rn;
        logic     wreg;
        logic     m2reg;
    } stage_t;

    // Register 0 is hardwired to zero, so it never creates a dependency.
    function automatic logic reg_hit(input logic rd, input reg_idx_t src,
                                     input reg_idx_t dst);
        return rd && (src == dst) && (src != '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_sel.sv
`default_nettype none
// ============================================================================
// Module   : fwd_sel
// Brief    : Combinational forward-select for one ID operand from tracked
//            EX/MEM destination state; EX wins over MEM.
// Revision : 1.0
// ============================================================================
module fwd_sel
    import fwd_hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] src,
    input  logic             use_src,
    input  logic [REG_W-1:0] ern,
    input  logic             ewreg,
    input  logic             em2reg,
    input  logic [REG_W-1:0] mrn,
    input  logic             mwreg,
    input  logic             mm2reg,
    output logic [1:0]       sel
);

    logic w_ex_hit;
    logic w_mem_hit;

    assign w_ex_hit  = reg_hit(use_src, src, ern) && ewreg;
    assign w_mem_hit = reg_hit(use_src, src, mrn) && mwreg;

    always_comb begin
        sel = FWD_RF;
        if (w_ex_hit && !em2reg) begin
            sel = FWD_EXALU;
        end else if (w_mem_hit && mm2reg) begin
            sel = FWD_MEMDO;
        end else if (w_mem_hit && !mm2reg) begin
            sel = FWD_MEMALU;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_ctrl
// Brief    : Pipeline forwarding and load-use hazard control with a
//            saturating stall-cycle counter.
// Revision : 1.0
// ============================================================================
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             clrn,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic             use_rs,
    input  logic             use_rt,
    input  logic [REG_W-1:0] rn,
    input  logic             wreg,
    input  logic             m2reg,
    output logic [1:0]       fwda,
    output logic [1:0]       fwdb,
    output logic             wpcir,
    output logic             ewreg_o,
    output logic             mwreg_o,
    output logic [15:0]      stall_cnt
);

    localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

    stage_t      r_ex;
    stage_t      r_mem;
    logic [15:0] r_stall_cnt;

    logic        w_load_use;
    logic [1:0]  w_sel_a;
    logic [1:0]  w_sel_b;

    // A load in EX cannot supply its data until MEM, so a dependent ID
    // instruction must wait exactly one cycle.
    assign w_load_use = r_ex.wreg && r_ex.m2reg &&
                        (reg_hit(use_rs, rs, r_ex.rn) ||
                         reg_hit(use_rt, rt, r_ex.rn));

    assign wpcir = ~w_load_use;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_ex        <= '0;
            r_mem       <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_mem <= r_ex;
            if (wpcir) begin
                r_ex <= '{rn: rn, wreg: wreg, m2reg: m2reg};
            end else begin
                r_ex <= '0;
            end
            if (!wpcir && (r_stall_cnt != C_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    fwd_sel u_fwd_a (
        .src     (rs),
        .use_src (use_rs),
        .ern     (r_ex.rn),
        .ewreg   (r_ex.wreg),
        .em2reg  (r_ex.m2reg),
        .mrn     (r_mem.rn),
        .mwreg   (r_mem.wreg),
        .mm2reg  (r_mem.m2reg),
        .sel     (w_sel_a)
    );

    fwd_sel u_fwd_b (
        .src     (rt),
        .use_src (use_rt),
        .ern     (r_ex.rn),
        .ewreg   (r_ex.wreg),
        .em2reg  (r_ex.m2reg),
        .mrn     (r_mem.rn),
        .mwreg   (r_mem.wreg),
        .mm2reg  (r_mem.m2reg),
        .sel     (w_sel_b)
    );

    assign fwda      = wpcir ? w_sel_a : FWD_RF;
    assign fwdb      = wpcir ? w_sel_b : FWD_RF;
    assign ewreg_o   = r_ex.wreg;
    assign mwreg_o   = r_mem.wreg;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwd_hazard_ctrl
// Brief    : Self-checking bench: directed hazard scenarios plus random
//            instruction streams against a producer-history reference model.
// Revision : 1.0
// ============================================================================
module tb_fwd_hazard_ctrl;

    logic        clk = 1'b0;
    logic        clrn;
    logic [4:0]  rs, rt, rn;
    logic        use_rs, use_rt, wreg, m2reg;
    logic [1:0]  fwda, fwdb;
    logic        wpcir, ewreg_o, mwreg_o;
    logic [15:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    // Model: in-flight producers, index 0 = one ahead (EX), 1 = two ahead (MEM).
    logic [4:0] m_rn [2];
    logic       m_wr [2];
    logic       m_ld [2];
    int         m_cnt;

    always #5 clk = ~clk;

    fwd_hazard_ctrl dut (
        .clk       (clk),
        .clrn      (clrn),
        .rs        (rs),
        .rt        (rt),
        .use_rs    (use_rs),
        .use_rt    (use_rt),
        .rn        (rn),
        .wreg      (wreg),
        .m2reg     (m2reg),
        .fwda      (fwda),
        .fwdb      (fwdb),
        .wpcir     (wpcir),
        .ewreg_o   (ewreg_o),
        .mwreg_o   (mwreg_o),
        .stall_cnt (stall_cnt)
    );

    function automatic logic m_stall();
        return m_wr[0] && m_ld[0] && (m_rn[0] != 5'd0) &&
               ((use_rs && m_rn[0] == rs) || (use_rt && m_rn[0] == rt));
    endfunction

    // Nearest in-flight producer of src supplies the value.
    function automatic logic [1:0] m_fwd(input logic u, input logic [4:0] src);
        if (m_stall() || !u || src == 5'd0) return 2'b00;
        for (int s = 0; s < 2; s++) begin
            if (m_wr[s] && m_rn[s] == src) begin
                if (s == 0) return 2'b01;
                return m_ld[s] ? 2'b11 : 2'b10;
            end
        end
        return 2'b00;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 2; s++) begin
            m_rn[s] = 5'd0; m_wr[s] = 1'b0; m_ld[s] = 1'b0;
        end
        m_cnt = 0;
    endtask

    task automatic set_id(input logic [4:0] a, input logic ua, input logic [4:0] b,
                          input logic ub, input logic [4:0] d, input logic w,
                          input logic ld);
        rs = a; use_rs = ua; rt = b; use_rt = ub; rn = d; wreg = w; m2reg = ld;
        #1;
    endtask

    task automatic clk_step();
        logic st;
        st = m_stall();
        @(posedge clk);
        m_rn[1] = m_rn[0]; m_wr[1] = m_wr[0]; m_ld[1] = m_ld[0];
        if (st) begin
            m_rn[0] = 5'd0; m_wr[0] = 1'b0; m_ld[0] = 1'b0;
            if (m_cnt < 65535) m_cnt++;
        end else begin
            m_rn[0] = rn; m_wr[0] = wreg; m_ld[0] = m2reg;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        clrn = 1'b0;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        clrn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clrn = 1'b0;
        model_clear();
        set_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd1, 1'b1, 1'b1);
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (fwda !== 2'b00) begin errors++; $display("FAIL reset_fwda got=%b exp=00", fwda); end
        checks++; if (fwdb !== 2'b00) begin errors++; $display("FAIL reset_fwdb got=%b exp=00", fwdb); end
        checks++; if (wpcir !== 1'b1) begin errors++; $display("FAIL reset_wpcir got=%b exp=1", wpcir); end
        checks++; if (ewreg_o !== 1'b0 || mwreg_o !== 1'b0) begin errors++; $display("FAIL reset_wreg got=%b%b exp=00", ewreg_o, mwreg_o); end
        checks++; if (stall_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt got=%h exp=0000", stall_cnt); end
        clrn = 1'b1;
        #1;
    endtask

    task automatic test_alu_fwd();
        do_reset();
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        clk_step();
        set_id(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        checks++; if (fwda !== 2'b01) begin errors++; $display("FAIL alu_fwda got=%b exp=01", fwda); end
        checks++; if (wpcir !== 1'b1) begin errors++; $display("FAIL alu_wpcir got=%b exp=1", wpcir); end
        checks++; if (ewreg_o !== 1'b1) begin errors++; $display("FAIL alu_ewreg got=%b exp=1", ewreg_o); end
        clk_step();
    endtask

    task automatic test_two_apart();
        do_reset();
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        clk_step();
        set_id(5'd1, 1'b1, 5'd2, 1'b1, 5'd12, 1'b1, 1'b0);
        clk_step();
        set_id(5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
        checks++; if (fwdb !== 2'b10) begin errors++; $display("FAIL two_apart_fwdb got=%b exp=10", fwdb); end
        checks++; if (mwreg_o !== 1'b1) begin errors++; $display("FAIL two_apart_mwreg got=%b exp=1", mwreg_o); end
        clk_step();
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1);
        clk_step();
        set_id(5'd3, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
        checks++; if (wpcir !== 1'b0) begin errors++; $display("FAIL lu_stall_wpcir got=%b exp=0", wpcir); end
        checks++; if (fwda !== 2'b00) begin errors++; $display("FAIL lu_stall_fwda got=%b exp=00", fwda); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL lu_cnt_before got=%h exp=0000", stall_cnt); end
        clk_step();
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt_after got=%h exp=0001", stall_cnt); end
        checks++; if (fwda !== 2'b11) begin errors++; $display("FAIL lu_fwda_memdo got=%b exp=11", fwda); end
        checks++; if (wpcir !== 1'b1) begin errors++; $display("FAIL lu_resume_wpcir got=%b exp=1", wpcir); end
        checks++; if (ewreg_o !== 1'b0) begin errors++; $display("FAIL lu_bubble_ewreg got=%b exp=0", ewreg_o); end
        clk_step();
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt_hold got=%h exp=0001", stall_cnt); end
    endtask

    task automatic test_ex_priority();
        do_reset();
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
        clk_step();
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
        clk_step();
        set_id(5'd9, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0);
        checks++; if (fwda !== 2'b01) begin errors++; $display("FAIL ex_prio_fwda got=%b exp=01", fwda); end
        checks++; if (fwdb !== 2'b01) begin errors++; $display("FAIL ex_prio_fwdb got=%b exp=01", fwdb); end
        clk_step();
    endtask

    task automatic test_reg0();
        do_reset();
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        clk_step();
        set_id(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
        checks++; if (fwda !== 2'b00) begin errors++; $display("FAIL reg0_fwda got=%b exp=00", fwda); end
        checks++; if (fwdb !== 2'b00) begin errors++; $display("FAIL reg0_fwdb got=%b exp=00", fwdb); end
        checks++; if (wpcir !== 1'b1) begin errors++; $display("FAIL reg0_wpcir got=%b exp=1", wpcir); end
        clk_step();
        checks++; if (fwda !== 2'b00 || fwdb !== 2'b00) begin errors++; $display("FAIL reg0_mem got=%b/%b exp=00/00", fwda, fwdb); end
        clk_step();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1);
        clk_step();
        set_id(5'd4, 1'b1, 5'd4, 1'b1, 5'd10, 1'b1, 1'b0);
        checks++; if (wpcir !== 1'b0) begin errors++; $display("FAIL rms_pre_wpcir got=%b exp=0", wpcir); end
        clrn = 1'b0;
        model_clear();
        #1;
        checks++; if (wpcir !== 1'b1) begin errors++; $display("FAIL rms_wpcir got=%b exp=1", wpcir); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rms_cnt got=%h exp=0000", stall_cnt); end
        checks++; if (ewreg_o !== 1'b0 || mwreg_o !== 1'b0) begin errors++; $display("FAIL rms_track got=%b%b exp=00", ewreg_o, mwreg_o); end
        @(posedge clk);
        @(negedge clk);
        clrn = 1'b1;
        #1;
        checks++; if (fwda !== 2'b00 || fwdb !== 2'b00 || wpcir !== 1'b1) begin
            errors++; $display("FAIL rms_post got=%b/%b/%b exp=00/00/1", fwda, fwdb, wpcir);
        end
        clk_step();
    endtask

    task automatic test_saturation();
        do_reset();
        force dut.r_stall_cnt = 16'hFFFE;
        #1;
        release dut.r_stall_cnt;
        #1;
        m_cnt = 65534;
        checks++; if (stall_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_preload got=%h exp=fffe", stall_cnt); end
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
        clk_step();
        set_id(5'd6, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
        clk_step();
        checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got=%h exp=ffff", stall_cnt); end
        checks++; if (fwda !== 2'b11) begin errors++; $display("FAIL sat_fwda got=%b exp=11", fwda); end
        clk_step();
        set_id(5'd6, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0);
        checks++; if (wpcir !== 1'b0) begin errors++; $display("FAIL sat_stall2 got=%b exp=0", wpcir); end
        clk_step();
        checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got=%h exp=ffff", stall_cnt); end
    endtask

    task automatic test_random();
        logic held;
        do_reset();
        held = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!held) begin
                set_id(5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)),
                       1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
            end else begin
                #1;
            end
            checks++; if (fwda !== m_fwd(use_rs, rs)) begin errors++; $display("FAIL rnd_fwda i=%0d got=%b exp=%b", i, fwda, m_fwd(use_rs, rs)); end
            checks++; if (fwdb !== m_fwd(use_rt, rt)) begin errors++; $display("FAIL rnd_fwdb i=%0d got=%b exp=%b", i, fwdb, m_fwd(use_rt, rt)); end
            checks++; if (wpcir !== !m_stall()) begin errors++; $display("FAIL rnd_wpcir i=%0d got=%b exp=%b", i, wpcir, !m_stall()); end
            held = m_stall();
            clk_step();
            checks++; if (stall_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL rnd_cnt i=%0d got=%0d exp=%0d", i, stall_cnt, m_cnt); end
            checks++; if (ewreg_o !== m_wr[0] || mwreg_o !== m_wr[1]) begin
                errors++; $display("FAIL rnd_track i=%0d got=%b%b exp=%b%b", i, ewreg_o, mwreg_o, m_wr[0], m_wr[1]);
            end
        end
    endtask

    initial begin
        clrn = 1'b0;
        rs = '0; rt = '0; rn = '0;
        use_rs = 1'b0; use_rt = 1'b0; wreg = 1'b0; m2reg = 1'b0;
        model_clear();
        @(negedge clk);
        test_reset();
        test_alu_fwd();
        test_two_apart();
        test_load_use();
        test_ex_priority();
        test_reg0();
        test_reset_mid_stall();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
